fractal_renderer: RTL and testbench

Parametrised escape-time fractal engine that walks a SCREEN_W×SCREEN_H pixel grid in row-major order. For each pixel it runs the z ← z² + c iteration in signed fixed point and emits one VGA plot strobe with a 3-bit colour. It supersedes the fixed 320×240, 16-iteration Mandelbrot block. New capabilities: runtime viewport (origin and step), runtime iteration limit, Julia mode, a full-precision escape test, and a busy flag. It sits between the top-level control logic and the VGA framebuffer adapter.

---
 rtl/fractal_renderer_if.sv | 47 ++++
 rtl/fractal_renderer.sv | 257 +++++++++++++++++++++++++
 tb/tb_fractal_renderer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fractal_renderer_if.sv
// -----------------------------------------------------------------------------
// fractal_renderer_if
//   Control / pixel-output bundle between the top-level control logic and the
//   fractal renderer.
//   master : control side. Drives start, mode, max_iter and the viewport /
//            Julia constants. Receives busy, done and the VGA plot stream.
//   slave  : renderer side. The same signals with the directions reversed.
//   start        frame request, honoured only while the renderer is idle/done
//   mode         0 = Mandelbrot, 1 = Julia
//   max_iter     iteration limit
//   cx_min/cy_min  coordinate of pixel (0,0)
//   step         per-pixel coordinate increment on both axes
//   julia_cr/ci  Julia constant c
//   busy/done    frame status
//   vga_x/y/colour/plot  one-cycle pixel write strobe and its payload
// -----------------------------------------------------------------------------
interface fractal_renderer_if #(
   parameter int WIDTH  = 32,
   parameter int ITER_W = 16,
   parameter int X_W    = 9,
   parameter int Y_W    = 8
);
   logic                    start;
   logic                    mode;
   logic [ITER_W-1:0]       max_iter;
   logic signed [WIDTH-1:0] cx_min;
   logic signed [WIDTH-1:0] cy_min;
   logic signed [WIDTH-1:0] step;
   logic signed [WIDTH-1:0] julia_cr;
   logic signed [WIDTH-1:0] julia_ci;
   logic                    busy;
   logic                    done;
   logic [X_W-1:0]          vga_x;
   logic [Y_W-1:0]          vga_y;
   logic [2:0]              vga_colour;
   logic                    vga_plot;

   modport master (
      output start, mode, max_iter, cx_min, cy_min, step, julia_cr, julia_ci,
      input  busy, done, vga_x, vga_y, vga_colour, vga_plot
   );

   modport slave (
      input  start, mode, max_iter, cx_min, cy_min, step, julia_cr, julia_ci,
      output busy, done, vga_x, vga_y, vga_colour, vga_plot
   );
endinterface

// File: rtl/fractal_renderer.sv
// -----------------------------------------------------------------------------
// fractal_renderer
//   Escape-time fractal engine. Walks a SCREEN_W x SCREEN_H grid in row-major
//   order, iterates z <- z^2 + c in signed WIDTH-bit fixed point (FRAC fraction
//   bits) one step per cycle, and emits one plot strobe per pixel with a 3-bit
//   colour (0 = in set, otherwise the wrapping 1..7 escape counter).
//   Ports:
//     clk   clock, all state on the rising edge
//     rstn  asynchronous active-low reset
//     bus   fractal_renderer_if.slave (control inputs, status, VGA strobe)
//   The interface instance must be parameterised with the same WIDTH, ITER_W,
//   X_W and Y_W as this module.
// -----------------------------------------------------------------------------
module fractal_renderer #(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 22,
   parameter int ITER_W   = 16,
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240,
   parameter int X_W      = 9,
   parameter int Y_W      = 8
) (
   input  logic                clk,
   input  logic                rstn,
   fractal_renderer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_ITER,
      S_PLOT,
      S_DONE
   } state_t;

   localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
   // 4.0 in the unshifted 2*FRAC fraction domain of a raw product sum
   localparam logic [2*WIDTH-1:0] ESC_TH = (2*WIDTH)'(4) << (2*FRAC);

   state_t state_q, state_d;

   // frame-constant copies of the control inputs
   logic                    mode_q,     mode_d;
   logic [ITER_W-1:0]       max_iter_q, max_iter_d;
   logic signed [WIDTH-1:0] cx_min_q,   cx_min_d;
   logic signed [WIDTH-1:0] step_q,     step_d;
   logic signed [WIDTH-1:0] jcr_q,      jcr_d;
   logic signed [WIDTH-1:0] jci_q,      jci_d;

   // pixel walker
   logic [X_W-1:0]          i_q,  i_d;
   logic [Y_W-1:0]          j_q,  j_d;
   logic signed [WIDTH-1:0] px_q, px_d;
   logic signed [WIDTH-1:0] py_q, py_d;

   // iteration state
   logic signed [WIDTH-1:0] zr_q, zr_d;
   logic signed [WIDTH-1:0] zi_q, zi_d;
   logic signed [WIDTH-1:0] cr_q, cr_d;
   logic signed [WIDTH-1:0] ci_q, ci_d;
   logic [ITER_W-1:0]       n_q,  n_d;
   logic [2:0]              k_q,  k_d;

   // registered outputs
   logic                    busy_q,   busy_d;
   logic                    done_q,   done_d;
   logic                    plot_q,   plot_d;
   logic [X_W-1:0]          x_q,      x_d;
   logic [Y_W-1:0]          y_q,      y_d;
   logic [2:0]              colour_q, colour_d;

   // ---------------------------------------------------------------------------
   // Arithmetic on the current z. Products are full 2*WIDTH; the escape test
   // uses them unshifted so it sees every bit, while the update path takes
   // the FRAC-shifted low WIDTH bits and is allowed to wrap.
   // ---------------------------------------------------------------------------
   logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ri;
   logic [2*WIDTH-1:0]        mag2;
   logic signed [WIDTH-1:0]   m_ri;
   logic signed [WIDTH-1:0]   zr_nxt, zi_nxt;
   logic                      escape;

   assign p_rr   = zr_q * zr_q;
   assign p_ii   = zi_q * zi_q;
   assign p_ri   = zr_q * zi_q;
   // both squares are non-negative and at most 2^(2*WIDTH-2), so no overflow
   assign mag2   = $unsigned(p_rr) + $unsigned(p_ii);
   assign escape = (mag2 > ESC_TH);
   assign m_ri   = WIDTH'(p_ri >>> FRAC);
   assign zr_nxt = WIDTH'(p_rr >>> FRAC) - WIDTH'(p_ii >>> FRAC) + cr_q;
   assign zi_nxt = (m_ri <<< 1) + ci_q;

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // Next state and datapath next values
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      max_iter_d = max_iter_q;
      cx_min_d   = cx_min_q;
      step_d     = step_q;
      jcr_d      = jcr_q;
      jci_d      = jci_q;
      i_d        = i_q;
      j_d        = j_q;
      px_d       = px_q;
      py_d       = py_q;
      zr_d       = zr_q;
      zi_d       = zi_q;
      cr_d       = cr_q;
      ci_d       = ci_q;
      n_d        = n_q;
      k_d        = k_q;
      busy_d     = busy_q;
      done_d     = done_q;
      plot_d     = 1'b0;
      x_d        = x_q;
      y_d        = y_q;
      colour_d   = colour_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               mode_d     = bus.mode;
               max_iter_d = bus.max_iter;
               cx_min_d   = bus.cx_min;
               step_d     = bus.step;
               jcr_d      = bus.julia_cr;
               jci_d      = bus.julia_ci;
               i_d        = '0;
               j_d        = '0;
               px_d       = bus.cx_min;
               py_d       = bus.cy_min;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               state_d    = S_INIT;
            end
         end

         S_INIT: begin
            zr_d    = px_q;
            zi_d    = py_q;
            cr_d    = mode_q ? jcr_q : px_q;
            ci_d    = mode_q ? jci_q : py_q;
            n_d     = '0;
            k_d     = 3'd1;
            state_d = S_ITER;
         end

         S_ITER: begin
            if (escape || (n_q == max_iter_q)) begin
               // escape wins over the limit when both hold on the same z
               colour_d = escape ? k_q : 3'd0;
               plot_d   = 1'b1;
               x_d      = i_q;
               y_d      = j_q;
               state_d  = S_PLOT;
            end else begin
               zr_d = zr_nxt;
               zi_d = zi_nxt;
               n_d  = n_q + ITER_W'(1);
               k_d  = (k_q == 3'd7) ? 3'd1 : k_q + 3'd1;
            end
         end

         S_PLOT: begin
            if (i_q < X_LAST) begin
               i_d     = i_q + X_W'(1);
               px_d    = px_q + step_q;
               state_d = S_INIT;
            end else if (j_q < Y_LAST) begin
               i_d     = '0;
               px_d    = cx_min_q;
               j_d     = j_q + Y_W'(1);
               py_d    = py_q + step_q;
               state_d = S_INIT;
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mode_q     <= 1'b0;
         max_iter_q <= '0;
         cx_min_q   <= '0;
         step_q     <= '0;
         jcr_q      <= '0;
         jci_q      <= '0;
         i_q        <= '0;
         j_q        <= '0;
         px_q       <= '0;
         py_q       <= '0;
         zr_q       <= '0;
         zi_q       <= '0;
         cr_q       <= '0;
         ci_q       <= '0;
         n_q        <= '0;
         k_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         plot_q     <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         colour_q   <= '0;
      end else begin
         mode_q     <= mode_d;
         max_iter_q <= max_iter_d;
         cx_min_q   <= cx_min_d;
         step_q     <= step_d;
         jcr_q      <= jcr_d;
         jci_q      <= jci_d;
         i_q        <= i_d;
         j_q        <= j_d;
         px_q       <= px_d;
         py_q       <= py_d;
         zr_q       <= zr_d;
         zi_q       <= zi_d;
         cr_q       <= cr_d;
         ci_q       <= ci_d;
         n_q        <= n_d;
         k_q        <= k_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         plot_q     <= plot_d;
         x_q        <= x_d;
         y_q        <= y_d;
         colour_q   <= colour_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.vga_plot   = plot_q;
   assign bus.vga_x      = x_q;
   assign bus.vga_y      = y_q;
   assign bus.vga_colour = colour_q;

endmodule

// File: tb/tb_fractal_renderer.sv
// -----------------------------------------------------------------------------
// tb_fractal_renderer
//   Directed bench on a 4x3 grid. Time t counts cycles after the edge that
//   accepted start: t=0 is the INIT cycle, a pixel with m updates strobes at
//   t = m+2, and consecutive strobes are m+3 apart.
// -----------------------------------------------------------------------------
module tb_fractal_renderer;

   localparam int WIDTH = 32;
   localparam int FRAC  = 22;
   localparam int ITW   = 16;
   localparam int SW    = 4;
   localparam int SH    = 3;
   localparam int XW    = 2;
   localparam int YW    = 2;

   localparam logic signed [WIDTH-1:0] F0    = 32'sd0;
   localparam logic signed [WIDTH-1:0] F1P5  = 32'sd6291456;   // 1.5
   localparam logic signed [WIDTH-1:0] F2    = 32'sd8388608;   // 2.0
   localparam logic signed [WIDTH-1:0] F3    = 32'sd12582912;  // 3.0
   localparam logic signed [WIDTH-1:0] F0P3  = 32'sd1258291;   // ~0.3

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;
   int t        = 0;
   int ts;
   bit any_busy, any_plot;

   fractal_renderer_if #(.WIDTH(WIDTH), .ITER_W(ITW), .X_W(XW), .Y_W(YW)) bus ();

   fractal_renderer #(
      .WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITW),
      .SCREEN_W(SW), .SCREEN_H(SH), .X_W(XW), .Y_W(YW)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step_cyc();
      @(posedge clk);
      @(negedge clk);
      t++;
   endtask

   task automatic set_frame(input logic md, input int mi,
                            input logic signed [WIDTH-1:0] cx,
                            input logic signed [WIDTH-1:0] cy,
                            input logic signed [WIDTH-1:0] st,
                            input logic signed [WIDTH-1:0] jr);
      bus.mode     = md;
      bus.max_iter = ITW'(mi);
      bus.cx_min   = cx;
      bus.cy_min   = cy;
      bus.step     = st;
      bus.julia_cr = jr;
      bus.julia_ci = F0;
   endtask

   // pulse start across one edge; afterwards t=0 is the INIT cycle
   task automatic do_start();
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      t = 0;
   endtask

   task automatic next_strobe(output int at);
      at = -1;
      for (int c = 0; c < 400; c++) begin
         step_cyc();
         if (bus.vga_plot === 1'b1) begin
            at = t;
            break;
         end
      end
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         step_cyc();
      end
      chk(tag, {63'd0, seen}, 64'd1);
   endtask

   initial begin
      bus.start = 1'b0;
      set_frame(1'b0, 0, F0, F0, F0, F0);

      // ---- reset state
      @(negedge clk);
      chk("rst_busy",   bus.busy,       0);
      chk("rst_done",   bus.done,       0);
      chk("rst_plot",   bus.vga_plot,   0);
      chk("rst_x",      bus.vga_x,      0);
      chk("rst_y",      bus.vga_y,      0);
      chk("rst_colour", bus.vga_colour, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // ---- grid walk, max_iter=0, start pulsed mid-frame is ignored
      set_frame(1'b0, 0, F0, F0, F0, F0);
      do_start();
      chk("grid_busy_t0", bus.busy, 1);
      chk("grid_done_t0", bus.done, 0);
      for (int s = 0; s < SW*SH; s++) begin
         next_strobe(ts);
         chk($sformatf("grid_t%0d", s),   ts,             2 + 3*s);
         chk($sformatf("grid_x%0d", s),   bus.vga_x,      s % SW);
         chk($sformatf("grid_y%0d", s),   bus.vga_y,      s / SW);
         chk($sformatf("grid_col%0d", s), bus.vga_colour, 0);
         if (s == 3) begin
            bus.start = 1'b1;
            step_cyc();
            bus.start = 1'b0;
         end
      end
      step_cyc();
      chk("grid_done_t", t,        36);
      chk("grid_done",   bus.done, 1);
      chk("grid_busy",   bus.busy, 0);
      step_cyc();
      chk("grid_plot_after", bus.vga_plot, 0);

      // ---- restart from DONE with a new step of 3.0
      set_frame(1'b0, 0, F0, F0, F3, F0);
      do_start();
      chk("rs_done_fall", bus.done, 0);
      chk("rs_busy",      bus.busy, 1);
      next_strobe(ts);
      chk("rs_t0",   ts,             2);
      chk("rs_x0",   bus.vga_x,      0);
      chk("rs_col0", bus.vga_colour, 0);
      next_strobe(ts);
      chk("rs_t1",   ts,             5);
      chk("rs_x1",   bus.vga_x,      1);
      chk("rs_col1", bus.vga_colour, 1);
      wait_done("rs_done");

      // ---- immediate escape, z0 = 3.0
      set_frame(1'b0, 16, F3, F0, F0, F0);
      do_start();
      next_strobe(ts);
      chk("imm_t",   ts,             2);
      chk("imm_col", bus.vga_colour, 1);
      wait_done("imm_done");

      // ---- mag2 == 4.0 does not escape; escapes on the next iteration
      set_frame(1'b0, 16, F2, F0, F0, F0);
      do_start();
      next_strobe(ts);
      chk("bnd_t0",  ts,             3);
      chk("bnd_col", bus.vga_colour, 2);
      next_strobe(ts);
      chk("bnd_t1",  ts,             7);
      wait_done("bnd_done");

      // ---- Julia c=0, z0=1.5
      set_frame(1'b1, 16, F1P5, F0, F0, F0);
      do_start();
      next_strobe(ts);
      chk("jul_t",   ts,             3);
      chk("jul_col", bus.vga_colour, 2);
      wait_done("jul_done");

      // ---- Mandelbrot c=0 stays in set for max_iter=16
      set_frame(1'b0, 16, F0, F0, F0, F0);
      do_start();
      next_strobe(ts);
      chk("in_t0",  ts,             18);
      chk("in_col", bus.vga_colour, 0);
      next_strobe(ts);
      chk("in_t1",  ts,             37);
      wait_done("in_done");

      // ---- Julia non-escaping, max_iter=20, then reset mid-ITER
      set_frame(1'b1, 20, F0, F0, F0, F0);
      do_start();
      next_strobe(ts);
      chk("j20_t",   ts,             22);
      chk("j20_col", bus.vga_colour, 0);
      while (t < 30) step_cyc();
      rstn = 1'b0;
      #1;
      chk("mrst_busy", bus.busy,       0);
      chk("mrst_done", bus.done,       0);
      chk("mrst_plot", bus.vga_plot,   0);
      chk("mrst_x",    bus.vga_x,      0);
      chk("mrst_col",  bus.vga_colour, 0);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("mrst_busy_held", bus.busy, 0);
      rstn = 1'b1;
      any_busy = 1'b0;
      any_plot = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step_cyc();
         any_busy |= (bus.busy !== 1'b0);
         any_plot |= (bus.vga_plot !== 1'b0);
      end
      chk("post_rst_busy", any_busy, 0);
      chk("post_rst_plot", any_plot, 0);

      // ---- colour counter wraps: Julia c=0.3, escapes at n=12 -> colour 6
      set_frame(1'b1, 20, F0, F0, F0, F0P3);
      do_start();
      next_strobe(ts);
      chk("wrap_t",   ts,             14);
      chk("wrap_col", bus.vga_colour, 6);
      chk("wrap_x",   bus.vga_x,      0);
      chk("wrap_y",   bus.vga_y,      0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
